decode_group: RTL
=================

Name: decode_group

Overview:
- Parametrised, N-wide successor of the single-lane decode stage.
- Accepts a fetch group of WIDTH {pc, inst} packets from the instruction queue and decodes each lane to register addresses, immediate, class flags and static branch target.
- Assigns program-order load/store ages across the whole group.
- Results are held in a registered output stage with valid/ready backpressure toward rename/ROB allocation; the whole stage is flushed on mispredict.

Parameters:
- WIDTH, 2: decode lanes per group; lane 0 is oldest.
- AGE_W, 16: width of the load/store age counter.
- XLEN, 32: data/pc width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- branch_mispredict  in  1  flush.
- in_valid  in  1  group valid.
- in_ready  out  1  stage can accept a group this cycle.
- in_lane_valid  in  WIDTH  per-lane valid mask; must be contiguous from lane 0.
- in_packet  in  64*WIDTH  lane i = bits [64i+63:64i]; {pc[63:32], inst[31:0]}.
- out_valid  out  1  registered group valid.
- out_ready  in  1  downstream accepts the group.
- out_lane_valid  out  WIDTH  registered lane mask.
- out_pc  out  XLEN*WIDTH  per-lane pc.
- out_inst  out  32*WIDTH  per-lane inst.
- out_rs1_addr, out_rs2_addr, out_rd_addr  out  5*WIDTH each  per-lane register addresses.
- out_imm  out  XLEN*WIDTH  per-lane selected immediate.
- out_regf_we, out_is_load, out_is_store, out_is_branch, out_is_jump, out_illegal  out  WIDTH each  per-lane flags.
- out_br_target  out  XLEN*WIDTH  pc+b_imm for branches, pc+j_imm for jal, else 0.
- out_age  out  AGE_W*WIDTH  age for memory lanes, 0 otherwise.

Behaviour:
- Reset (rst=0, asynchronous): all registered outputs 0, age counter 0, out_valid=0.
- in_ready = ~out_valid | out_ready (combinational, single-entry pipeline register).
- Accept when in_valid & in_ready: decoded group registered next edge; latency 1 cycle.
- Invalid lanes register all fields 0.
- out_valid holds with stable data while out_ready=0 (no drop, no overwrite).
- out_valid falls after handshake when no new group is accepted in the same cycle.
- Per-lane decode (RV32I opcodes):
  - lui, auipc, jal: rs1=rs2=0, U/J immediate.
  - jalr: rs2=0, I immediate, is_branch=is_jump=1.
  - jal: is_jump=1, is_branch=0.
  - br: rd=0, B immediate, is_branch=1, regf_we=0.
  - load: rs2=0, I immediate, is_load=1.
  - store: rd=0, S immediate, is_store=1, regf_we=0.
  - imm: rs2=0, I immediate.
  - reg: immediate 0.
  - csr: regf_we=0.
  - Any other opcode: illegal=1, regf_we=0, all addresses 0.
  - regf_we=1 for lui/auipc/jal/jalr/load/imm/reg, and forced 0 when rd=0.
- Immediates are sign-extended per the RV32I formats. Targets wrap mod 2^XLEN.
- Age assignment:
  - Lane i age = age_q + (number of valid load/store lanes j<i).
  - On accept, age_q += total valid memory lanes in the group.
  - All age arithmetic is mod 2^AGE_W; wrap from all-ones to 0 is legal.
- Flush (branch_mispredict=1):
  - Next edge: out_valid=0, out_lane_valid=0, age_q=0.
  - Any group offered that cycle is discarded.
  - Flush has priority over simultaneous accept and handshake.
  - in_ready is unaffected by flush.
- A non-contiguous in_lane_valid mask is a protocol violation; assert in simulation.

Test Plan:
- Reset/pass-through:
  - Stimulus: deassert rst mid-run.
  - Required: outputs 0 immediately.
  - Stimulus: release reset, offer lane0 addi x5,x1,-1 (0xFFF08293, pc 0x1000).
  - Required: next cycle out_rd_addr=5, rs1=1, rs2=0, imm=0xFFFFFFFF, regf_we=1.
- Group age:
  - Stimulus: lanes {lw x2,0(x3); sw x2,4(x3)} from age_q=0, then {add, lw}.
  - Required: ages 0,1; then lane0 age 0, lane1 age 2; age_q=3.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with in_valid held.
  - Required: in_ready=0, outputs stable.
  - Stimulus: raise out_ready with a new group pending.
  - Required: new group appears the next cycle, no bubble, no duplication.
- Flush:
  - Stimulus: assert branch_mispredict while accepting a store group, age_q=7.
  - Required: out_valid=0 next cycle, age_q=0; next load gets age 0.
- Branch/jump targets:
  - Stimulus: beq at pc 0x2000, offset -8.
  - Required: target 0x1FF8, rd=0, regf_we=0.
  - Stimulus: jal x1,+0x800 at 0x2004.
  - Required: target 0x2804, is_jump=1, is_branch=0.
- Wrap/illegal:
  - Stimulus: age_q=0xFFFF, two loads.
  - Required: ages 0xFFFF and 0x0000; age_q=1.
  - Stimulus: opcode 0x7F.
  - Required: illegal=1, regf_we=0.

Source files
------------

// File: rtl/decode_group.sv
// N-wide RV32I decode stage: per-lane field extraction, class flags, static branch
// targets and program-order load/store ages, held in a one-entry valid/ready register.
module decode_group #(
    parameter int WIDTH = 2,
    parameter int AGE_W = 16,
    parameter int XLEN  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  branch_mispredict,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_lane_valid,
    input  logic [64*WIDTH-1:0]   in_packet,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_lane_valid,
    output logic [XLEN*WIDTH-1:0] out_pc,
    output logic [32*WIDTH-1:0]   out_inst,
    output logic [5*WIDTH-1:0]    out_rs1_addr,
    output logic [5*WIDTH-1:0]    out_rs2_addr,
    output logic [5*WIDTH-1:0]    out_rd_addr,
    output logic [XLEN*WIDTH-1:0] out_imm,
    output logic [WIDTH-1:0]      out_regf_we,
    output logic [WIDTH-1:0]      out_is_load,
    output logic [WIDTH-1:0]      out_is_store,
    output logic [WIDTH-1:0]      out_is_branch,
    output logic [WIDTH-1:0]      out_is_jump,
    output logic [WIDTH-1:0]      out_illegal,
    output logic [XLEN*WIDTH-1:0] out_br_target,
    output logic [AGE_W*WIDTH-1:0] out_age
);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_CSR   = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            we;
        logic            ld;
        logic            st;
        logic            br;
        logic            jp;
        logic            ill;
        logic [XLEN-1:0] tgt;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] inst, input logic [XLEN-1:0] pc);
        dec_t            d;
        logic [XLEN-1:0] i_imm, s_imm, b_imm, u_imm, j_imm;
        i_imm = XLEN'($signed(inst[31:20]));
        s_imm = XLEN'($signed({inst[31:25], inst[11:7]}));
        b_imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
        u_imm = XLEN'($signed({inst[31:12], 12'h000}));
        j_imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
        d      = '0;
        d.pc   = pc;
        d.inst = inst;
        case (inst[6:0])
            OP_LUI, OP_AUIPC: begin
                d.rd  = inst[11:7];
                d.imm = u_imm;
                d.we  = 1'b1;
            end
            OP_JAL: begin
                d.rd  = inst[11:7];
                d.imm = j_imm;
                d.jp  = 1'b1;
                d.we  = 1'b1;
                d.tgt = pc + j_imm;
            end
            OP_JALR: begin
                // register-relative target is unknown here, so no static target
                d.rs1 = inst[19:15];
                d.rd  = inst[11:7];
                d.imm = i_imm;
                d.br  = 1'b1;
                d.jp  = 1'b1;
                d.we  = 1'b1;
            end
            OP_BR: begin
                d.rs1 = inst[19:15];
                d.rs2 = inst[24:20];
                d.imm = b_imm;
                d.br  = 1'b1;
                d.tgt = pc + b_imm;
            end
            OP_LOAD, OP_IMM: begin
                d.rs1 = inst[19:15];
                d.rd  = inst[11:7];
                d.imm = i_imm;
                d.ld  = (inst[6:0] == OP_LOAD);
                d.we  = 1'b1;
            end
            OP_STORE: begin
                d.rs1 = inst[19:15];
                d.rs2 = inst[24:20];
                d.imm = s_imm;
                d.st  = 1'b1;
            end
            OP_REG: begin
                d.rs1 = inst[19:15];
                d.rs2 = inst[24:20];
                d.rd  = inst[11:7];
                d.we  = 1'b1;
            end
            OP_CSR: begin
                d.rs1 = inst[19:15];
                d.rd  = inst[11:7];
            end
            default: d.ill = 1'b1;
        endcase
        if (d.rd == 5'd0) d.we = 1'b0;
        return d;
    endfunction

    dec_t             d_lane [WIDTH];
    logic [AGE_W-1:0] d_age  [WIDTH];
    dec_t             q_lane [WIDTH];
    logic [AGE_W-1:0] q_age  [WIDTH];
    logic [AGE_W-1:0] age_q;
    logic [AGE_W-1:0] age_next;
    logic             accept;

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    // running memory-op count gives each lane its program-order age
    always_comb begin
        age_next = age_q;
        for (int i = 0; i < WIDTH; i++) begin
            d_lane[i] = '0;
            d_age[i]  = '0;
            if (in_lane_valid[i])
                d_lane[i] = decode(in_packet[64*i +: 32], XLEN'(in_packet[64*i+32 +: 32]));
            if (d_lane[i].ld || d_lane[i].st) begin
                d_age[i] = age_next;
                age_next = age_next + AGE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid      <= 1'b0;
            out_lane_valid <= '0;
            age_q          <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                q_lane[i] <= '0;
                q_age[i]  <= '0;
            end
        end else if (branch_mispredict) begin
            out_valid      <= 1'b0;
            out_lane_valid <= '0;
            age_q          <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                q_lane[i] <= '0;
                q_age[i]  <= '0;
            end
        end else if (accept) begin
            out_valid      <= 1'b1;
            out_lane_valid <= in_lane_valid;
            age_q          <= age_next;
            for (int i = 0; i < WIDTH; i++) begin
                q_lane[i] <= d_lane[i];
                q_age[i]  <= d_age[i];
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_comb begin
        out_pc        = '0;
        out_inst      = '0;
        out_rs1_addr  = '0;
        out_rs2_addr  = '0;
        out_rd_addr   = '0;
        out_imm       = '0;
        out_regf_we   = '0;
        out_is_load   = '0;
        out_is_store  = '0;
        out_is_branch = '0;
        out_is_jump   = '0;
        out_illegal   = '0;
        out_br_target = '0;
        out_age       = '0;
        for (int i = 0; i < WIDTH; i++) begin
            out_pc[XLEN*i +: XLEN]        = q_lane[i].pc;
            out_inst[32*i +: 32]          = q_lane[i].inst;
            out_rs1_addr[5*i +: 5]        = q_lane[i].rs1;
            out_rs2_addr[5*i +: 5]        = q_lane[i].rs2;
            out_rd_addr[5*i +: 5]         = q_lane[i].rd;
            out_imm[XLEN*i +: XLEN]       = q_lane[i].imm;
            out_regf_we[i]                = q_lane[i].we;
            out_is_load[i]                = q_lane[i].ld;
            out_is_store[i]               = q_lane[i].st;
            out_is_branch[i]              = q_lane[i].br;
            out_is_jump[i]                = q_lane[i].jp;
            out_illegal[i]                = q_lane[i].ill;
            out_br_target[XLEN*i +: XLEN] = q_lane[i].tgt;
            out_age[AGE_W*i +: AGE_W]     = q_age[i];
        end
    end

    // lane masks must be a run of ones starting at lane 0
    assert property (@(posedge clk) disable iff (!rst)
        in_valid |-> ((in_lane_valid & (in_lane_valid + WIDTH'(1))) == '0));

endmodule
